// File: rtl/netlist_sequencer.sv
// ============================================================================
// netlist_sequencer: walks a netlist store gate by gate for each circuit cycle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module netlist_sequencer #(
    parameter int S = 14,
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [C-1:0] num_cc,
    input  logic         nl_ready,
    input  logic [S-1:0] dff_size,
    input  logic [S-1:0] gate_size,
    input  logic [3:0]   g_logic,
    input  logic         gate_ready,
    output logic [S-1:0] rd_addr,
    output logic         prep_next_cycle,
    output logic         gate_valid,
    output logic [S-1:0] gate_idx,
    output logic         is_xor,
    output logic         last_gate,
    output logic [C-1:0] cc,
    output logic [31:0]  xor_count,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_NL = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [C-1:0] c_CC_ONE   = {{(C-1){1'b0}}, 1'b1};
    localparam logic [S-1:0] c_ADDR_ONE = {{(S-1){1'b0}}, 1'b1};
    localparam logic [S:0]   c_TOT_ONE  = {{S{1'b0}}, 1'b1};

    state_t       r_state;
    logic [S-1:0] r_rd_addr;
    logic [S:0]   r_total;
    logic [C-1:0] r_num_cc;
    logic [C-1:0] r_cc;
    logic [31:0]  r_xor_count;
    logic         r_gate_valid;
    logic         r_prep;

    logic         w_is_xor;
    logic         w_last;
    logic         w_xfer;

    // Total is one bit wider so dff_size+gate_size cannot overflow.
    assign w_is_xor = r_gate_valid && (g_logic == 4'b0110 || g_logic == 4'b1001);
    assign w_last   = r_gate_valid && ({1'b0, r_rd_addr} == (r_total - c_TOT_ONE));
    assign w_xfer   = r_gate_valid && gate_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd_addr    <= '0;
            r_total      <= '0;
            r_num_cc     <= '0;
            r_cc         <= '0;
            r_xor_count  <= '0;
            r_gate_valid <= 1'b0;
            r_prep       <= 1'b0;
        end else begin
            r_prep <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_num_cc    <= (num_cc == '0) ? c_CC_ONE : num_cc;
                        r_cc        <= '0;
                        r_xor_count <= '0;
                        r_rd_addr   <= '0;
                        r_state     <= ST_WAIT_NL;
                    end
                end
                ST_WAIT_NL: begin
                    r_rd_addr <= '0;
                    if (nl_ready) begin
                        r_total <= {1'b0, dff_size} + {1'b0, gate_size};
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_rd_addr <= '0;
                    if (r_total != '0) begin
                        r_gate_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        if (w_is_xor)
                            r_xor_count <= r_xor_count + 32'd1;
                        if (w_last) begin
                            r_gate_valid <= 1'b0;
                            r_state      <= ST_NEXT;
                        end else begin
                            r_rd_addr <= r_rd_addr + c_ADDR_ONE;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_cc == (r_num_cc - c_CC_ONE)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_prep    <= 1'b1;
                        r_cc      <= r_cc + c_CC_ONE;
                        r_rd_addr <= '0;
                        r_state   <= ST_WAIT_NL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr         = r_rd_addr;
    assign gate_idx        = r_rd_addr;
    assign gate_valid      = r_gate_valid;
    assign is_xor          = w_is_xor;
    assign last_gate       = w_last;
    assign prep_next_cycle = r_prep;
    assign cc              = r_cc;
    assign xor_count       = r_xor_count;
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done            = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_netlist_sequencer.sv
// ============================================================================
// tb_netlist_sequencer: directed self-checking bench for netlist_sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_netlist_sequencer;

    localparam int S = 14;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [C-1:0] num_cc = '0;
    logic         nl_ready = 1'b0;
    logic [S-1:0] dff_size = '0;
    logic [S-1:0] gate_size = '0;
    logic [3:0]   g_logic;
    logic         gate_ready = 1'b0;
    logic [S-1:0] rd_addr;
    logic         prep_next_cycle;
    logic         gate_valid;
    logic [S-1:0] gate_idx;
    logic         is_xor;
    logic         last_gate;
    logic [C-1:0] cc;
    logic [31:0]  xor_count;
    logic         busy;
    logic         done;

    logic [3:0]   mem [16];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_xfer = 0;
    int           n_prep = 0;
    int           n_valid = 0;
    int           n_skip = 0;
    logic [S-1:0] r_prev_addr = '0;

    netlist_sequencer #(.S(S), .C(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_cc(num_cc),
        .nl_ready(nl_ready), .dff_size(dff_size), .gate_size(gate_size),
        .g_logic(g_logic), .gate_ready(gate_ready), .rd_addr(rd_addr),
        .prep_next_cycle(prep_next_cycle), .gate_valid(gate_valid),
        .gate_idx(gate_idx), .is_xor(is_xor), .last_gate(last_gate),
        .cc(cc), .xor_count(xor_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Netlist store model: truth table of the addressed gate.
    assign g_logic = mem[rd_addr[3:0]];

    always @(negedge clk) begin
        if (!rst) begin
            if (gate_valid && gate_ready) n_xfer++;
            if (prep_next_cycle) n_prep++;
            if (gate_valid) n_valid++;
            if (!(rd_addr == r_prev_addr || rd_addr == r_prev_addr + 1'b1 || rd_addr == '0))
                n_skip++;
        end
        r_prev_addr <= rd_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_cc = C'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int d, input int g);
        dff_size = S'(d);
        gate_size = S'(g);
        nl_ready = 1'b1;
        tick();
        nl_ready = 1'b0;
    endtask

    // Returns cycles from nl_ready to prep_next_cycle (or to done).
    task automatic run_cc(input int d, input int g, output int lat);
        load(d, g);
        lat = 1;
        while (!prep_next_cycle && !done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int b_xfer;
        int b_prep;
        int b_valid;
        int n;

        for (int i = 0; i < 16; i++) mem[i] = 4'b0000;

        // Reset state
        tick();
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_valid", 32'(gate_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_xor", xor_count, 0);
        rst = 1'b0;
        tick();

        // Basic run
        mem[0] = 4'b0110; mem[1] = 4'b1000; mem[2] = 4'b1001;
        gate_ready = 1'b1;
        b_xfer = n_xfer; b_prep = n_prep;
        do_start(1);
        check("b_busy", 32'(busy), 1);
        load(0, 3);
        check("b_load_valid", 32'(gate_valid), 0);
        tick();
        check("b_idx0", 32'(gate_idx), 0);
        check("b_valid0", 32'(gate_valid), 1);
        check("b_xor0", 32'(is_xor), 1);
        check("b_last0", 32'(last_gate), 0);
        tick();
        check("b_idx1", 32'(gate_idx), 1);
        check("b_xor1", 32'(is_xor), 0);
        tick();
        check("b_idx2", 32'(gate_idx), 2);
        check("b_last2", 32'(last_gate), 1);
        tick();
        check("b_next_valid", 32'(gate_valid), 0);
        check("b_xor_count", xor_count, 2);
        tick();
        check("b_done", 32'(done), 1);
        check("b_busy_done", 32'(busy), 0);
        check("b_xfers", 32'(n_xfer - b_xfer), 3);
        check("b_prep", 32'(n_prep - b_prep), 0);

        // Backpressure
        mem[0] = 4'b1001; mem[1] = 4'b0001;
        gate_ready = 1'b0;
        b_xfer = n_xfer;
        do_start(1);
        load(0, 2);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(gate_valid), 1);
            check("bp_hold_idx", 32'(gate_idx), 0);
            if (i < 2) tick();
        end
        gate_ready = 1'b1;
        tick();
        check("bp_idx1", 32'(gate_idx), 1);
        check("bp_last1", 32'(last_gate), 1);
        wait_done("bp_done");
        check("bp_xfers", 32'(n_xfer - b_xfer), 2);
        check("bp_xor", xor_count, 1);

        // Multi-cycle
        b_xfer = n_xfer; b_prep = n_prep;
        do_start(3);
        for (int k = 0; k < 3; k++) begin
            run_cc(1, 1, lat);
            check("mc_latency", 32'(lat), 5);
            if (k < 2) begin
                check("mc_prep", 32'(prep_next_cycle), 1);
                check("mc_cc", 32'(cc), 32'(k + 1));
            end else begin
                check("mc_done", 32'(done), 1);
            end
        end
        check("mc_xfers", 32'(n_xfer - b_xfer), 6);
        check("mc_prep_count", 32'(n_prep - b_prep), 2);

        // Empty netlist
        b_prep = n_prep; b_valid = n_valid;
        do_start(2);
        run_cc(0, 0, lat);
        check("em_latency", 32'(lat), 3);
        check("em_cc", 32'(cc), 1);
        run_cc(0, 0, lat);
        check("em_done", 32'(done), 1);
        check("em_valid", 32'(n_valid - b_valid), 0);
        check("em_prep", 32'(n_prep - b_prep), 1);

        // Reset mid-ISSUE
        for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 1) ? 4'b0110 : 4'b0001;
        do_start(1);
        load(0, 10);
        n = 0;
        while (gate_idx != 5 && n < 30) begin
            tick();
            n++;
        end
        check("rs_at_idx5", 32'(gate_idx), 5);
        rst = 1'b1;
        #1;
        check("rs_rd_addr", 32'(rd_addr), 0);
        check("rs_gate_idx", 32'(gate_idx), 0);
        check("rs_valid", 32'(gate_valid), 0);
        check("rs_xor", xor_count, 0);
        check("rs_cc", 32'(cc), 0);
        check("rs_outs", {28'd0, prep_next_cycle, busy, done, last_gate}, 0);
        tick();
        rst = 1'b0;
        b_xfer = n_xfer;
        tick();
        check("rs_no_xfer", 32'(n_xfer - b_xfer), 0);

        // Fresh run, with ignored start/nl_ready during ISSUE
        mem[0] = 4'b1001; mem[1] = 4'b0000; mem[2] = 4'b0110;
        gate_ready = 1'b0;
        b_prep = n_prep;
        do_start(1);
        check("fr_xor_clr", xor_count, 0);
        load(0, 3);
        tick();
        check("fr_idx0", 32'(gate_idx), 0);
        start = 1'b1; nl_ready = 1'b1; num_cc = 16'd5; gate_size = 14'd9;
        tick();
        start = 1'b0; nl_ready = 1'b0;
        check("ig_idx", 32'(gate_idx), 0);
        check("ig_valid", 32'(gate_valid), 1);
        check("ig_cc", 32'(cc), 0);
        check("ig_busy", 32'(busy), 1);
        gate_ready = 1'b1;
        wait_done("ig_done");
        check("ig_xor", xor_count, 2);
        check("ig_prep", 32'(n_prep - b_prep), 0);
        check("addr_no_skip", 32'(n_skip), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/netlist_sequencer.md
NETLIST_SEQUENCER -- requirements
Module: netlist_sequencer

Interface
REQ-001 Parameter S, default 14, width of netlist indices and sizes; matches the netlist store.
REQ-002 Parameter C, default 16, width of the sequential clock-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a run; sampled only in IDLE or DONE.
REQ-006 num_cc  in  C  number of sequential circuit cycles to garble; sampled on accepted start.
REQ-007 nl_ready  in  1  netlist-store ready pulse; gate data for index 0 is valid the following cycle.
REQ-008 dff_size, gate_size  in  S each  netlist entry counts; sampled on each accepted nl_ready.
REQ-009 g_logic  in  4  gate truth table of the entry addressed by rd_addr.
REQ-010 rd_addr  out  S  gate index presented to the netlist store.
REQ-011 prep_next_cycle  out  1  one-cycle pulse asking the store to re-prepare for the next circuit cycle.
REQ-012 gate_valid  out  1  the gate at gate_idx is offered to the garbling engine.
REQ-013 gate_ready  in  1  the engine accepts the gate; transfer occurs when gate_valid && gate_ready.
REQ-014 gate_idx  out  S  index of the offered gate; equals rd_addr while gate_valid.
REQ-015 is_xor  out  1  g_logic == 4'b0110 or 4'b1001 while gate_valid, else 0.
REQ-016 last_gate  out  1  gate_valid && gate_idx == dff_size+gate_size-1.
REQ-017 cc  out  C  index of the current circuit cycle.
REQ-018 xor_count  out  32  cumulative count of XOR/XNOR gates transferred in the run.
REQ-019 busy  out  1  high in every state except IDLE and DONE.
REQ-020 done  out  1  high while in DONE.

Function
REQ-021 States SHALL be IDLE, WAIT_NL, LOAD, ISSUE, NEXT, DONE.
REQ-022 IDLE/DONE + start: latch num_cc (0 treated as 1); clear cc and xor_count; go to WAIT_NL.
REQ-023 WAIT_NL: rd_addr = 0, no outputs active; on nl_ready, latch total = dff_size+gate_size and go to LOAD.
REQ-024 LOAD: lasts one cycle; rd_addr = 0; go to ISSUE if total != 0, else go to NEXT.
REQ-025 ISSUE: gate_valid = 1; rd_addr holds while !gate_ready.
REQ-026 ISSUE, non-last transfer: rd_addr += 1 on the next edge.
REQ-027 rd_addr SHALL never change by more than +1 per cycle, and never decrement except returning to 0 in WAIT_NL or LOAD.
REQ-028 ISSUE, transfer with last_gate: go to NEXT; xor_count increments on every transfer where is_xor = 1.
REQ-029 NEXT, if cc == num_cc-1: go to DONE with no prep_next_cycle pulse.
REQ-030 NEXT, otherwise: pulse prep_next_cycle for exactly one cycle, cc += 1, go to WAIT_NL.
REQ-031 Throughput: with gate_ready held high, one gate per cycle; a circuit cycle of T gates takes T+3 cycles from nl_ready to prep_next_cycle.
REQ-032 gate_valid, once high, SHALL stay high with stable gate_idx until the transfer completes.
REQ-033 start while busy SHALL be ignored.
REQ-034 nl_ready outside WAIT_NL SHALL be ignored.
REQ-035 cc SHALL wrap modulo 2^C; xor_count SHALL wrap modulo 2^32.

Reset
REQ-036 While rst is high, or when rst asserts in any state including mid-ISSUE: state = IDLE.
REQ-037 Under the same conditions, all outputs SHALL be 0: rd_addr, gate_idx, cc, xor_count, gate_valid, prep_next_cycle, busy, done.
REQ-038 No transfer SHALL be reported in the cycle rst deasserts.

Verification
REQ-039 Basic run: num_cc=1, dff_size=0, gate_size=3, g_logic = 0110, 1000, 1001, gate_ready=1 -> gate_idx 0,1,2 on consecutive cycles; last_gate on idx 2; xor_count=2; done; no prep_next_cycle.
REQ-040 Backpressure: gate_size=2, gate_ready low 3 cycles on idx 0 -> gate_valid and gate_idx=0 held 3 cycles, then idx 0 and idx 1 transfer; rd_addr never skips.
REQ-041 Multi-cycle: num_cc=3, dff_size=1, gate_size=1 -> two prep_next_cycle pulses; cc steps 0,1,2; 6 transfers total; done.
REQ-042 Empty netlist: dff_size=gate_size=0, num_cc=2 -> no gate_valid; one prep_next_cycle pulse; done.
REQ-043 Reset mid-operation: rst asserted during ISSUE at idx 5 -> all outputs 0 and IDLE immediately; a fresh start then restarts at idx 0 with xor_count=0.
REQ-044 Ignored events: start pulsed during ISSUE and nl_ready pulsed during ISSUE -> no state, counter or rd_addr change.
